// File: rtl/i2s_tx.sv
// i2s_tx: 16-bit stereo I2S transmitter with a one-frame holding register.
// Frames go out MSB first, left then right, with the one-bclk I2S delay.
module i2s_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] left_sample,
    input  logic [15:0] right_sample,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        bclk,
    output logic        l_r_clk,
    output logic        sdata,
    output logic        underrun
);

    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [4:0]  bit_nxt;
    logic [31:0] shift;
    logic [15:0] hold_l;
    logic [15:0] hold_r;
    logic        hold_full;
    logic        wrap;
    logic        fall;
    logic        load;
    logic        xfer;

    assign wrap         = (div_cnt == 8'(BCLK_DIV - 1));
    assign fall         = wrap & bclk;
    assign load         = fall & (bit_cnt == 5'd0);
    assign xfer         = sample_valid & ~hold_full;
    assign bit_nxt      = bit_cnt + 5'd1;
    assign sample_ready = ~hold_full;
    assign sdata        = shift[31];

    // Clock divider: bclk toggles each time div_cnt wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // Slot counter and word select, both advanced on bclk fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
            l_r_clk <= 1'b0;
        end else if (fall) begin
            bit_cnt <= bit_nxt;
            l_r_clk <= bit_nxt[4];
        end
    end

    // Serializer: reload the frame at slot 1, otherwise shift on fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift    <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= load & ~hold_full;
            if (load) begin
                shift <= {hold_l, hold_r};
            end else if (fall) begin
                shift <= {shift[30:0], 1'b0};
            end
        end
    end

    // Holding register: filled on handshake, emptied by a load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_l    <= '0;
            hold_r    <= '0;
            hold_full <= 1'b0;
        end else begin
            if (xfer) begin
                hold_l <= left_sample;
                hold_r <= right_sample;
            end
            hold_full <= xfer | (hold_full & ~load);
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx with a timing-arithmetic model.
// Loads fall at fixed clk offsets; frames are queued and checked per cycle.
`timescale 1ns/1ps
module tb_i2s_tx;

    localparam int D  = 4;
    localparam int FR = 64 * D;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] left_sample = '0;
    logic [15:0] right_sample = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        bclk;
    logic        l_r_clk;
    logic        sdata;
    logic        underrun;

    typedef struct packed {
        logic [31:0] frame;
        logic        urun;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          n = 0;
    logic        m_full = 1'b0;
    logic [31:0] m_hold = '0;

    always #5 clk = ~clk;

    i2s_tx #(.BCLK_DIV(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .left_sample (left_sample),
        .right_sample(right_sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .bclk        (bclk),
        .l_r_clk     (l_r_clk),
        .sdata       (sdata),
        .underrun    (underrun)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s n=%0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    function automatic bit is_load_at(input int t);
        return (t >= 2 * D) && (((t - 2 * D) % FR) == 0);
    endfunction

    // Reference model: cycle n since reset release; loads every frame.
    always @(posedge clk) begin : model
        int   nn;
        logic ld;
        logic xf;
        if (!reset) begin
            n      <= 0;
            m_full <= 1'b0;
            m_hold <= '0;
            sbq.delete();
        end else begin
            nn = n + 1;
            ld = is_load_at(nn);
            xf = sample_valid && !m_full;
            n <= nn;
            if (ld) sbq.push_back('{frame: m_hold, urun: !m_full});
            if (xf) begin
                m_hold <= {left_sample, right_sample};
                m_full <= 1'b1;
            end else if (ld) begin
                m_full <= 1'b0;
            end
        end
    end

    // Monitor: pops a frame at each load and checks every output.
    always @(negedge clk) begin : monitor
        int          b;
        logic        exp_u;
        logic        exp_sd;
        logic        fell;
        logic [31:0] cur;
        logic        p_bclk;
        logic        p_lr;
        logic        p_sd;
        exp_t        e;
        if (!reset) begin
            check("rst_bclk", bclk, 0);
            check("rst_lr", l_r_clk, 0);
            check("rst_sdata", sdata, 0);
            check("rst_underrun", underrun, 0);
            check("rst_ready", sample_ready, 1);
            cur    = '0;
            p_bclk = 1'b0;
            p_lr   = 1'b0;
            p_sd   = 1'b0;
        end else begin
            exp_u = 1'b0;
            if (is_load_at(n)) begin
                if (sbq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_empty n=%0d: got none expected frame", n);
                end else begin
                    e     = sbq.pop_front();
                    cur   = e.frame;
                    exp_u = e.urun;
                end
            end
            if (n < 2 * D) begin
                exp_sd = 1'b0;
            end else begin
                b      = ((n - 2 * D) / (2 * D)) % 32;
                exp_sd = cur[31-b];
            end
            check("bclk", bclk, ((n / D) % 2) == 1);
            check("l_r_clk", l_r_clk, ((n / (2 * D)) % 32) >= 16);
            check("sdata", sdata, exp_sd);
            check("underrun", underrun, exp_u);
            check("ready", sample_ready, !m_full);
            fell = p_bclk && !bclk;
            if (l_r_clk !== p_lr || sdata !== p_sd)
                check("change_at_fall", fell, 1);
            p_bclk = bclk;
            p_lr   = l_r_clk;
            p_sd   = sdata;
        end
    end

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r,
                        input bit keep);
        int k;
        k = 0;
        left_sample  = l;
        right_sample = r;
        sample_valid = 1'b1;
        while (!sample_ready && k < 4 * FR) begin
            idle(1);
            k++;
        end
        if (!sample_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout n=%0d: got ready=0 expected 1", n);
        end
        idle(1);
        if (!keep) sample_valid = 1'b0;
    endtask

    task automatic wait_slot(input int s);
        int k;
        k = 0;
        while (((n / (2 * D)) % 32) != s && k < 2 * FR) begin
            idle(1);
            k++;
        end
    endtask

    initial begin
        int k;
        idle(5);
        reset = 1'b1;
        send(16'h8001, 16'h7FFE, 1'b0);
        idle(2 * FR);

        send(16'h1234, 16'hABCD, 1'b1);
        send(16'h5555, 16'hAAAA, 1'b0);
        idle(3 * FR);

        send(16'h00FF, 16'hFF00, 1'b0);
        idle(3 * FR);

        k = 0;
        while (!is_load_at(n + 1) && k < 2 * FR) begin
            idle(1);
            k++;
        end
        left_sample  = 16'h0F0F;
        right_sample = 16'hF0F0;
        sample_valid = 1'b1;
        idle(1);
        sample_valid = 1'b0;
        idle(2 * FR);

        repeat (6) begin
            idle(int'($urandom_range(0, 2 * FR)));
            send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        sample_valid = 1'b0;
        idle(2 * FR);

        wait_slot(2);
        send(16'hCAFE, 16'hBEEF, 1'b0);
        wait_slot(20);
        reset = 1'b0;
        idle(4);
        reset = 1'b1;
        idle(2 * FR + 16);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter: BCLK_DIV, 4, number of clk cycles per bclk half-period; legal values 2..255.
REQ-002 clk  input  1  high-speed system clock; all logic is on its rising edge.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 left_sample  input  16  signed left-channel sample, two's complement.
REQ-005 right_sample  input  16  signed right-channel sample, two's complement.
REQ-006 sample_valid  input  1  producer asserts this when left_sample and right_sample hold a frame.
REQ-007 sample_ready  output  1  high when the holding register is empty.
REQ-008 bclk  output  1  I2S bit clock to the DAC.
REQ-009 l_r_clk  output  1  I2S word select: 0 selects left, 1 selects right.
REQ-010 sdata  output  1  I2S serial data, MSB first.
REQ-011 underrun  output  1  one-clk pulse when a frame is reloaded without fresh data.

Function
REQ-012 Divider: div_cnt counts 0..BCLK_DIV-1 and wraps.
- bclk SHALL toggle in the cycle div_cnt wraps.
- A toggle from 1 to 0 is a "fall event".
REQ-013 Slot counter: bit_cnt (5 bits) SHALL increment on each fall event and wrap 31->0.
- One frame = 32 bclk periods = 64*BCLK_DIV clk cycles.
REQ-014 l_r_clk SHALL be registered.
- It equals 1 exactly while bit_cnt >= 16.
- It updates in the same cycle as bit_cnt, so it changes only at fall events.
REQ-015 Handshake: a transfer occurs in a cycle where sample_valid && sample_ready.
- On a transfer, both samples are captured into hold_l/hold_r and hold_full is set.
- sample_ready SHALL equal !hold_full.
REQ-016 Load event: the fall event on which bit_cnt becomes 1.
- shift[31:0] SHALL load {hold_l, hold_r}.
- hold_full SHALL clear unless a transfer occurs in the same cycle.
REQ-017 On every other fall event, shift SHALL shift left by one.
REQ-018 sdata SHALL equal shift[31] at all times, registered.
- Result: slots 1..16 carry left[15:0].
- Slots 17..31 carry right[15:1].
- Slot 0 of the next frame carries right[0], giving the standard I2S one-bclk MSB delay.
REQ-019 Underrun: at a load event with hold_full=0, shift SHALL reload the unchanged hold_l/hold_r, so the last frame repeats.
- underrun SHALL pulse high for exactly one clk in that cycle.
REQ-020 Simultaneous transfer and load event:
- If hold_full=1, the load uses the old hold contents; no transfer is possible because ready=0.
- If hold_full=0, an underrun occurs, and the incoming frame is captured for the next frame.
REQ-021 sample_valid without sample_ready SHALL be ignored; the producer must hold its data until the transfer.
REQ-022 The block SHALL place no timing constraint on sample_valid other than the handshake.
- Data SHALL be captured only on a transfer.

Reset
REQ-023 While reset=0, the following SHALL be held: bclk=0, l_r_clk=0, sdata=0, underrun=0, sample_ready=1.
- All internal state is zero: div_cnt, bit_cnt, shift, hold_l, hold_r, hold_full.
REQ-024 Reset assertion mid-frame SHALL immediately force the REQ-023 values, discarding any held or in-flight data.
REQ-025 After deassertion, the first bclk rise SHALL occur BCLK_DIV clk cycles later.
- The first fall event (the load event, slot 1) occurs 2*BCLK_DIV cycles later.

Verification (BCLK_DIV=4)
REQ-026 Reset release, then transfer left=0x8001, right=0x7FFE before the first fall:
- Over slots 1..16, sdata reads 1000000000000001.
- Over slots 17..31 and the next slot 0, sdata reads 0111111111111110.
- l_r_clk rises at the fall event entering slot 16.
REQ-027 Frame timing: after one frame, measure edge spacing.
- bclk period = 8 clk.
- l_r_clk period = 256 clk.
- l_r_clk and sdata change only in cycles where bclk falls.
REQ-028 Back-to-back: hold sample_valid=1 with a new frame every transfer (0x1234/0xABCD, then 0x5555/0xAAAA).
- Each frame is serialized exactly once, in order.
- underrun never pulses.
- sample_ready rises one clk after each load event.
REQ-029 Starvation: supply 0x00FF/0xFF00 once, then keep sample_valid=0.
- The frame repeats on every subsequent frame.
- underrun pulses once per frame, for 1 clk each, at each load event.
REQ-030 Transfer in the exact load-event cycle with hold_full=0:
- underrun pulses.
- The new frame transmits in the following frame.
- sample_ready=0 after that cycle.
REQ-031 Reset asserted at bit_cnt=20 with hold_full=1:
- Outputs are immediately at REQ-023 values.
- After release, the first frame transmits 0x0000/0x0000 with underrun.
